// File: rtl/decode_stage_hz.sv
// decode_stage_hz: instruction decode stage with register file, EX/MEM/WB
// operand forwarding, load-use and branch interlocks, in-decode branch and
// jump resolution with a one-beat wrong-path squash, and a registered ID/EX
// output with valid/ready handshaking.
module decode_stage_hz #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 16,
  localparam int RAW  = $clog2(NREG)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [XLEN-1:0]  i_pc,
  input  logic             i_ex_we,
  input  logic             i_ex_is_load,
  input  logic [RAW-1:0]   i_ex_waddr,
  input  logic [XLEN-1:0]  i_ex_data,
  input  logic             i_mem_we,
  input  logic             i_mem_is_load,
  input  logic [RAW-1:0]   i_mem_waddr,
  input  logic [XLEN-1:0]  i_mem_data,
  input  logic             i_wb_we,
  input  logic [RAW-1:0]   i_wb_waddr,
  input  logic [XLEN-1:0]  i_wb_data,
  input  logic             i_ex_ready,
  output logic             o_valid,
  output logic [XLEN-1:0]  o_op1,
  output logic [XLEN-1:0]  o_op2,
  output logic [XLEN-1:0]  o_imm,
  output logic [5:0]       o_opcode,
  output logic [5:0]       o_funct,
  output logic [RAW-1:0]   o_waddr,
  output logic             o_pcsrc,
  output logic [XLEN-1:0]  o_nextpc,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  // Register file and ID/EX state
  logic [XLEN-1:0]  rf_q [NREG];
  logic             valid_q, valid_d;
  logic [XLEN-1:0]  op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
  logic [5:0]       opcode_q, opcode_d, funct_q, funct_d;
  logic [RAW-1:0]   waddr_q, waddr_d;
  logic             squash_q, squash_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Instruction field decode
  logic [5:0]      opcode, funct;
  logic [RAW-1:0]  rs_idx, rt_idx, rd_idx;
  logic [XLEN-1:0] imm_sext;
  logic            is_beq, is_bne, is_j, is_jr, is_ctrl, uses_rs, uses_rt;

  assign opcode   = i_instr[31:26];
  assign funct    = i_instr[5:0];
  assign rs_idx   = i_instr[21 +: RAW];
  assign rt_idx   = i_instr[16 +: RAW];
  assign rd_idx   = i_instr[11 +: RAW];
  assign imm_sext = {{(XLEN-16){i_instr[15]}}, i_instr[15:0]};

  assign is_beq  = (opcode == OP_BEQ);
  assign is_bne  = (opcode == OP_BNE);
  assign is_j    = (opcode == OP_J);
  assign is_jr   = (opcode == OP_RTYPE) && (funct == FN_JR);
  // Instructions that compare or consume operands in decode need them final now
  assign is_ctrl = is_beq || is_bne || is_jr;
  assign uses_rs = !is_j;
  assign uses_rt = (opcode == OP_RTYPE) || is_beq || is_bne || (opcode == OP_SW);

  // Per-operand forwarding and dependency detection (gi=0: rs, gi=1: rt)
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic [RAW-1:0]  idx;
      logic            used, nz, ex_hit, mem_hit, wb_hit;
      logic [XLEN-1:0] val;

      assign idx     = (gi == 0) ? rs_idx : rt_idx;
      assign used    = (gi == 0) ? uses_rs : uses_rt;
      assign nz      = |idx;
      assign ex_hit  = i_ex_we  && nz && (i_ex_waddr  == idx);
      assign mem_hit = i_mem_we && nz && (i_mem_waddr == idx);
      assign wb_hit  = i_wb_we  && nz && (i_wb_waddr  == idx);

      // Youngest producer wins; index 0 is hard-wired to zero
      always_comb begin
        val = rf_q[idx];
        if (!nz)          val = '0;
        else if (ex_hit)  val = i_ex_data;
        else if (mem_hit) val = i_mem_data;
        else if (wb_hit)  val = i_wb_data;
      end
    end
  endgenerate

  logic [XLEN-1:0] fwd_op1, fwd_op2;
  logic            ex_dep, mem_dep, hazard, adv, accept, redirect;

  assign fwd_op1 = g_src[0].val;
  assign fwd_op2 = g_src[1].val;
  assign ex_dep  = (g_src[0].used && g_src[0].ex_hit)  || (g_src[1].used && g_src[1].ex_hit);
  assign mem_dep = (g_src[0].used && g_src[0].mem_hit) || (g_src[1].used && g_src[1].mem_hit);

  // Load results arrive too late for anyone; ALU results too late for decode compares
  assign hazard = (ex_dep && i_ex_is_load)
               || (is_ctrl && ex_dep)
               || (is_ctrl && mem_dep && i_mem_is_load);

  assign adv     = !valid_q || i_ex_ready;
  // A squashed beat is dropped without touching ID/EX, so it never waits
  assign o_ready = squash_q || (adv && !hazard);
  assign accept  = i_valid && o_ready && !squash_q;

  // Control-flow resolution
  always_comb begin
    redirect = 1'b0;
    o_nextpc = i_pc + (imm_sext << 2);
    if (is_j) begin
      redirect = 1'b1;
      o_nextpc = {i_pc[XLEN-1:28], i_instr[25:0], 2'b00};
    end else if (is_jr) begin
      redirect = 1'b1;
      o_nextpc = fwd_op1;
    end else if (is_beq) begin
      redirect = (fwd_op1 == fwd_op2);
    end else if (is_bne) begin
      redirect = (fwd_op1 != fwd_op2);
    end
  end

  assign o_pcsrc = !i_rst && accept && redirect;

  // Next-state for ID/EX payload, squash flag and stall counter
  always_comb begin
    valid_d  = valid_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    imm_d    = imm_q;
    opcode_d = opcode_q;
    funct_d  = funct_q;
    waddr_d  = waddr_q;
    squash_d = squash_q;
    cnt_d    = cnt_q;
    if (accept) begin
      valid_d  = 1'b1;
      op1_d    = fwd_op1;
      op2_d    = fwd_op2;
      imm_d    = imm_sext;
      opcode_d = opcode;
      funct_d  = funct;
      waddr_d  = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
    end else if (adv) begin
      valid_d = 1'b0;
    end
    if (o_pcsrc)                  squash_d = 1'b1;
    else if (squash_q && i_valid) squash_d = 1'b0;
    if (i_valid && hazard && !squash_q && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  // Register file write port; r0 is never written
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (i_wb_we && (i_wb_waddr != '0)) begin
      rf_q[i_wb_waddr] <= i_wb_data;
    end
  end

  // ID/EX, squash and counter state registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q  <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      imm_q    <= '0;
      opcode_q <= '0;
      funct_q  <= '0;
      waddr_q  <= '0;
      squash_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      imm_q    <= imm_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
      waddr_q  <= waddr_d;
      squash_q <= squash_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_op1       = op1_q;
  assign o_op2       = op2_q;
  assign o_imm       = imm_q;
  assign o_opcode    = opcode_q;
  assign o_funct     = funct_q;
  assign o_waddr     = waddr_q;
  assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
// tb_decode_stage_hz: scoreboard bench for decode_stage_hz. Expected ID/EX
// payloads are queued when an instruction is offered and popped when the
// stage hands it to execute. A second instance with a 2-bit stall counter
// shares all inputs to exercise counter saturation.
module tb_decode_stage_hz;
  localparam int XLEN = 32;
  localparam int RAW  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, i_valid, ex_we, ex_is_load, mem_we, mem_is_load, wb_we, ex_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc, ex_data, mem_data, wb_data;
  logic [RAW-1:0]  ex_waddr, mem_waddr, wb_waddr;

  logic            o_ready, o_valid, o_pcsrc;
  logic [XLEN-1:0] o_op1, o_op2, o_imm, o_nextpc;
  logic [5:0]      o_opcode, o_funct;
  logic [RAW-1:0]  o_waddr;
  logic [15:0]     o_stall_cnt;

  logic            b_ready, b_valid, b_pcsrc;
  logic [XLEN-1:0] b_op1, b_op2, b_imm, b_nextpc;
  logic [5:0]      b_opcode, b_funct;
  logic [RAW-1:0]  b_waddr;
  logic [1:0]      b_stall_cnt;

  decode_stage_hz #(.XLEN(XLEN), .NREG(32), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(instr), .i_pc(pc),
    .i_ex_we(ex_we), .i_ex_is_load(ex_is_load), .i_ex_waddr(ex_waddr), .i_ex_data(ex_data),
    .i_mem_we(mem_we), .i_mem_is_load(mem_is_load), .i_mem_waddr(mem_waddr), .i_mem_data(mem_data),
    .i_wb_we(wb_we), .i_wb_waddr(wb_waddr), .i_wb_data(wb_data),
    .i_ex_ready(ex_ready), .o_valid(o_valid), .o_op1(o_op1), .o_op2(o_op2), .o_imm(o_imm),
    .o_opcode(o_opcode), .o_funct(o_funct), .o_waddr(o_waddr),
    .o_pcsrc(o_pcsrc), .o_nextpc(o_nextpc), .o_stall_cnt(o_stall_cnt)
  );

  decode_stage_hz #(.XLEN(XLEN), .NREG(32), .CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(b_ready),
    .i_instr(instr), .i_pc(pc),
    .i_ex_we(ex_we), .i_ex_is_load(ex_is_load), .i_ex_waddr(ex_waddr), .i_ex_data(ex_data),
    .i_mem_we(mem_we), .i_mem_is_load(mem_is_load), .i_mem_waddr(mem_waddr), .i_mem_data(mem_data),
    .i_wb_we(wb_we), .i_wb_waddr(wb_waddr), .i_wb_data(wb_data),
    .i_ex_ready(ex_ready), .o_valid(b_valid), .o_op1(b_op1), .o_op2(b_op2), .o_imm(b_imm),
    .o_opcode(b_opcode), .o_funct(b_funct), .o_waddr(b_waddr),
    .o_pcsrc(b_pcsrc), .o_nextpc(b_nextpc), .o_stall_cnt(b_stall_cnt)
  );

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  waddr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t mk(input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] ins);
    exp_t e;
    e.op1    = op1;
    e.op2    = op2;
    e.imm    = {{16{ins[15]}}, ins[15:0]};
    e.opcode = ins[31:26];
    e.funct  = ins[5:0];
    e.waddr  = (ins[31:26] == 6'h00) ? ins[15:11] : ins[20:16];
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pcv);
    i_valid = 1'b1;
    instr   = ins;
    pc      = pcv;
  endtask

  task automatic clear_fwd();
    ex_we = 1'b0; ex_is_load = 1'b0; mem_we = 1'b0; mem_is_load = 1'b0; wb_we = 1'b0;
  endtask

  // Offer a redirecting instruction, then feed one wrong-path beat that must be dropped
  task automatic redirect_pair(input string tag, input logic [31:0] ins, input logic [31:0] pcv,
                               input logic [31:0] op1, input logic [31:0] op2,
                               input logic [31:0] tgt);
    drive(ins, pcv);
    #1;
    check({tag, "_ready"}, o_ready, 1'b1);
    check({tag, "_pcsrc"}, o_pcsrc, 1'b1);
    check({tag, "_nextpc"}, o_nextpc, tgt);
    sb_q.push_back(mk(op1, op2, ins));
    cyc();
    drive(rtype(5'd1, 5'd1, 5'd30, 6'h20), pcv + 32'd4);
    #1;
    check({tag, "_drop_ready"}, o_ready, 1'b1);
    check({tag, "_drop_pcsrc"}, o_pcsrc, 1'b0);
    cyc();
    check({tag, "_drop_bubble"}, o_valid, 1'b0);
  endtask

  // Output side: every handoff to execute must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (o_valid === 1'b1 && ex_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_extra", 1'b1, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("sb_op1", o_op1, e.op1);
        check("sb_op2", o_op2, e.op2);
        check("sb_imm", o_imm, e.imm);
        check("sb_opcode", o_opcode, e.opcode);
        check("sb_funct", o_funct, e.funct);
        check("sb_waddr", o_waddr, e.waddr);
        $display("txn t=%0t op=%0h fn=%0h rd=%0d op1=%0h op2=%0h imm=%0h",
                 $time, o_opcode, o_funct, o_waddr, o_op1, o_op2, o_imm);
      end
    end
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; instr = '0; pc = '0; ex_ready = 1'b1;
    ex_waddr = '0; mem_waddr = '0; wb_waddr = '0;
    ex_data = '0; mem_data = '0; wb_data = '0;
    clear_fwd();

    // Reset: a jump offered during reset must not redirect nor load
    drive({6'h02, 26'h40}, 32'h100);
    #1;
    check("rst_pcsrc", o_pcsrc, 1'b0);
    cyc();
    cyc();
    check("rst_valid", o_valid, 1'b0);
    check("rst_cnt", o_stall_cnt, 16'd0);
    check("rst_op1", o_op1, 32'd0);
    check("rst_imm", o_imm, 32'd0);
    check("rst_waddr", o_waddr, 5'd0);
    rst = 1'b0;
    i_valid = 1'b0;

    // Same-cycle WB of r5 is seen by the reader
    wb_we = 1'b1; wb_waddr = 5'd5; wb_data = 32'h11;
    drive(rtype(5'd5, 5'd0, 5'd7, 6'h20), 32'h10);
    #1;
    check("wb_fwd_ready", o_ready, 1'b1);
    sb_q.push_back(mk(32'h11, 32'h0, instr));
    cyc();
    check("wb_fwd_valid", o_valid, 1'b1);
    // Write to r0 is neither forwarded nor stored
    wb_waddr = 5'd0; wb_data = 32'hDEAD;
    drive(rtype(5'd0, 5'd5, 5'd8, 6'h20), 32'h14);
    sb_q.push_back(mk(32'h0, 32'h11, instr));
    cyc();
    wb_we = 1'b0;
    drive(rtype(5'd0, 5'd0, 5'd9, 6'h20), 32'h18);
    sb_q.push_back(mk(32'h0, 32'h0, instr));
    cyc();
    wb_we = 1'b1; wb_waddr = 5'd1; wb_data = 32'h1234;
    drive(rtype(5'd1, 5'd1, 5'd10, 6'h20), 32'h1C);
    sb_q.push_back(mk(32'h1234, 32'h1234, instr));
    cyc();

    // Forwarding priority EX > MEM > WB > regfile on r3
    ex_we = 1'b1;  ex_waddr = 5'd3;  ex_data = 32'hA;
    mem_we = 1'b1; mem_waddr = 5'd3; mem_data = 32'hB;
    wb_we = 1'b1;  wb_waddr = 5'd3;  wb_data = 32'hC;
    drive(rtype(5'd3, 5'd1, 5'd6, 6'h20), 32'h20);
    #1;
    check("prio_ready", o_ready, 1'b1);
    sb_q.push_back(mk(32'hA, 32'h1234, instr));
    cyc();
    ex_we = 1'b0;
    sb_q.push_back(mk(32'hB, 32'h1234, instr));
    cyc();
    mem_we = 1'b0;
    sb_q.push_back(mk(32'hC, 32'h1234, instr));
    cyc();
    wb_we = 1'b0;
    sb_q.push_back(mk(32'hC, 32'h1234, instr));
    cyc();
    ex_we = 1'b1;
    drive(rtype(5'd1, 5'd3, 5'd6, 6'h20), 32'h24);
    sb_q.push_back(mk(32'h1234, 32'hA, instr));
    cyc();
    clear_fwd();

    // Load-use: one stall, then the load sits in MEM and is forwarded
    ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd4; ex_data = 32'hBAD;
    drive(rtype(5'd4, 5'd1, 5'd6, 6'h20), 32'h28);
    #1;
    check("lu_ready", o_ready, 1'b0);
    cyc();
    exp_cnt++;
    check("lu_bubble", o_valid, 1'b0);
    check("lu_cnt", o_stall_cnt, exp_cnt);
    clear_fwd();
    mem_we = 1'b1; mem_is_load = 1'b1; mem_waddr = 5'd4; mem_data = 32'h44;
    #1;
    check("lu_ready2", o_ready, 1'b1);
    sb_q.push_back(mk(32'h44, 32'h1234, instr));
    cyc();
    check("lu_valid", o_valid, 1'b1);
    check("lu_cnt2", o_stall_cnt, exp_cnt);
    clear_fwd();

    // lw r2 then beq r2,r0: stall on EX load, then on MEM load, then taken
    ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd2;
    drive(itype(6'h04, 5'd2, 5'd0, 16'd5), 32'h200);
    #1;
    check("beq_st1_ready", o_ready, 1'b0);
    check("beq_st1_pcsrc", o_pcsrc, 1'b0);
    cyc();
    clear_fwd();
    mem_we = 1'b1; mem_is_load = 1'b1; mem_waddr = 5'd2;
    #1;
    check("beq_st2_ready", o_ready, 1'b0);
    cyc();
    exp_cnt += 2;
    check("beq_cnt", o_stall_cnt, exp_cnt);
    clear_fwd();
    redirect_pair("beq", itype(6'h04, 5'd2, 5'd0, 16'd5), 32'h200, 32'h0, 32'h0, 32'h214);
    drive(rtype(5'd1, 5'd1, 5'd11, 6'h20), 32'h218);
    #1;
    check("beq_after_ready", o_ready, 1'b1);
    sb_q.push_back(mk(32'h1234, 32'h1234, instr));
    cyc();
    check("beq_after_valid", o_valid, 1'b1);

    // Not-taken beq: no redirect, next beat accepted immediately
    drive(itype(6'h04, 5'd1, 5'd0, 16'd5), 32'h300);
    #1;
    check("nt_pcsrc", o_pcsrc, 1'b0);
    sb_q.push_back(mk(32'h1234, 32'h0, instr));
    cyc();
    drive(rtype(5'd1, 5'd0, 5'd12, 6'h20), 32'h304);
    sb_q.push_back(mk(32'h1234, 32'h0, instr));
    cyc();
    check("nt_next_valid", o_valid, 1'b1);

    // Taken bne; the dropped beat also has a load-use hazard (squash wins, not counted)
    drive(itype(6'h05, 5'd1, 5'd0, 16'd3), 32'h104);
    #1;
    check("bne_pcsrc", o_pcsrc, 1'b1);
    check("bne_nextpc", o_nextpc, 32'h110);
    sb_q.push_back(mk(32'h1234, 32'h0, instr));
    cyc();
    ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd1;
    drive(rtype(5'd1, 5'd0, 5'd13, 6'h20), 32'h108);
    #1;
    check("bne_drop_ready", o_ready, 1'b1);
    cyc();
    check("bne_drop_bubble", o_valid, 1'b0);
    check("bne_drop_cnt", o_stall_cnt, exp_cnt);
    clear_fwd();
    sb_q.push_back(mk(32'h1234, 32'h0, instr));
    cyc();
    check("bne_after_valid", o_valid, 1'b1);

    // Branch on an EX ALU result stalls one cycle; narrow counter saturates
    ex_we = 1'b1; ex_waddr = 5'd1; ex_data = 32'h1234;
    drive(itype(6'h04, 5'd1, 5'd1, 16'hFFFE), 32'h400);
    #1;
    check("brx_ready", o_ready, 1'b0);
    cyc();
    exp_cnt++;
    check("brx_cnt", o_stall_cnt, exp_cnt);
    check("sat_cnt", b_stall_cnt, 2'd3);
    clear_fwd();
    redirect_pair("brx", itype(6'h04, 5'd1, 5'd1, 16'hFFFE), 32'h400, 32'h1234, 32'h1234, 32'h3F8);

    // j and jr
    redirect_pair("j", {6'h02, 26'h40}, 32'h3000_0004, 32'h0, 32'h0, 32'h3000_0100);
    redirect_pair("jr", rtype(5'd1, 5'd0, 5'd0, 6'h08), 32'h500, 32'h1234, 32'h0, 32'h1234);

    // Backpressure: payload held, decode not ready, no stall counted
    drive(rtype(5'd1, 5'd1, 5'd20, 6'h20), 32'h600);
    sb_q.push_back(mk(32'h1234, 32'h1234, instr));
    cyc();
    ex_ready = 1'b0;
    drive(rtype(5'd1, 5'd0, 5'd21, 6'h20), 32'h604);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", o_ready, 1'b0);
      cyc();
      check("bp_valid", o_valid, 1'b1);
      check("bp_waddr", o_waddr, 5'd20);
      check("bp_op2", o_op2, 32'h1234);
    end
    check("bp_cnt", o_stall_cnt, exp_cnt);
    ex_ready = 1'b1;
    #1;
    check("bp_release_ready", o_ready, 1'b1);
    sb_q.push_back(mk(32'h1234, 32'h0, instr));
    cyc();
    check("bp_next_waddr", o_waddr, 5'd21);
    check("sat_hold", b_stall_cnt, 2'd3);

    // Reset while a squash is pending
    drive({6'h02, 26'h80}, 32'h700);
    #1;
    check("rs_j_pcsrc", o_pcsrc, 1'b1);
    sb_q.push_back(mk(32'h0, 32'h0, instr));
    cyc();
    rst = 1'b1;
    drive(rtype(5'd1, 5'd1, 5'd23, 6'h20), 32'h704);
    cyc();
    rst = 1'b0;
    check("rs_valid", o_valid, 1'b0);
    check("rs_cnt", o_stall_cnt, 16'd0);
    check("rs_cnt_sat", b_stall_cnt, 2'd0);
    drive(rtype(5'd1, 5'd1, 5'd22, 6'h20), 32'h800);
    #1;
    check("rs_first_ready", o_ready, 1'b1);
    sb_q.push_back(mk(32'h0, 32'h0, instr));
    cyc();
    check("rs_first_valid", o_valid, 1'b1);

    i_valid = 1'b0;
    cyc();
    cyc();
    check("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
